mem_access_unit: RTL and testbench

//   Initiator side of the data-memory port: sits between the MEM pipeline stage and the word-only data memory.

---
 rtl/mem_access_unit.sv | 123 ++++++++++++
 tb/tb_mem_access_unit.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Load/store initiator for a word-only data memory. Sub-word stores use read-modify-write; errors are flagged, not issued.
// Latency: error 1, load/word store 2, sub-word store 3 cycles to resp_valid; req_ready only in IDLE, no response backpressure.
module mem_access_unit #(
    parameter int RAM_SIZE_BIT = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] address,
    output logic [31:0] Wr_data,
    output logic        MemWr,
    output logic        MemRead,
    input  logic [31:0] Read_data
);

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    state_t      state_q, state_d;
    logic        we_q, uns_q, err_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q, wr_data_q, rdata_q;

    logic        accept, req_err;
    logic [31:0] sh_word, load_ext, merged;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    assign accept = req_valid && req_ready;

    always_comb begin
        req_err = 1'b0;
        if (req_size == 2'd3)                          req_err = 1'b1;
        if (req_size == 2'd1 && req_addr[0])           req_err = 1'b1;
        if (req_size == 2'd2 && req_addr[1:0] != 2'b0) req_err = 1'b1;
        if ((req_addr >> (RAM_SIZE_BIT + 2)) != 32'd0) req_err = 1'b1;
    end

    // Little-endian lane extraction for loads and lane insertion for sub-word stores.
    always_comb begin
        sh_word = Read_data >> {addr_q[1:0], 3'b000};
        byte_v  = sh_word[7:0];
        half_v  = addr_q[1] ? Read_data[31:16] : Read_data[15:0];
        if (size_q == 2'd0)
            load_ext = uns_q ? {24'd0, byte_v} : {{24{byte_v[7]}}, byte_v};
        else if (size_q == 2'd1)
            load_ext = uns_q ? {16'd0, half_v} : {{16{half_v[15]}}, half_v};
        else
            load_ext = Read_data;
        merged = Read_data;
        if (size_q == 2'd0)
            merged[{addr_q[1:0], 3'b000} +: 8] = wr_data_q[7:0];
        else
            merged[{addr_q[1], 4'b0000} +: 16] = wr_data_q[15:0];
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (req_err)                state_d = DONE;
                    else if (!req_we)           state_d = RD;
                    else if (req_size == 2'd2)  state_d = WR;
                    else                        state_d = RD;
                end
            end
            RD:      state_d = we_q ? WR : DONE;
            WR:      state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            we_q      <= 1'b0;
            uns_q     <= 1'b0;
            err_q     <= 1'b0;
            size_q    <= 2'd0;
            addr_q    <= 32'd0;
            wr_data_q <= 32'd0;
            rdata_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                we_q    <= req_we;
                uns_q   <= req_unsigned;
                err_q   <= req_err;
                size_q  <= req_size;
                addr_q  <= req_addr;
                rdata_q <= 32'd0;
                // Holds raw store data until a sub-word store replaces it with the merged word.
                if (req_we)
                    wr_data_q <= req_wdata;
            end else if (state_q == RD) begin
                if (we_q)
                    wr_data_q <= merged;
                else
                    rdata_q <= load_ext;
            end
        end
    end

    assign req_ready  = (state_q == IDLE) && reset;
    assign resp_valid = (state_q == DONE);
    assign resp_err   = (state_q == DONE) && err_q;
    assign resp_rdata = rdata_q;
    assign address    = {addr_q[31:2], 2'b00};
    assign Wr_data    = wr_data_q;
    assign MemRead    = (state_q == RD);
    assign MemWr      = (state_q == WR);

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: word memory model, directed scenarios and random requests against a lane-arithmetic reference.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] address;
    logic [31:0] Wr_data;
    logic        MemWr;
    logic        MemRead;
    logic [31:0] Read_data;

    mem_access_unit #(.RAM_SIZE_BIT(8)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .address(address), .Wr_data(Wr_data),
        .MemWr(MemWr), .MemRead(MemRead), .Read_data(Read_data)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:255];
    logic [31:0] ref_mem [0:255];
    logic        pl_en = 1'b0;
    logic [7:0]  pl_idx = 8'd0;
    logic [31:0] pl_dat = 32'd0;

    always @(posedge clk) begin
        if (pl_en)      mem[pl_idx] <= pl_dat;
        else if (MemWr) mem[address[9:2]] <= Wr_data;
    end
    assign Read_data = MemRead ? mem[address[9:2]] : 32'hA5A5_A5A5;

    int checks = 0;
    int errors = 0;
    logic [31:0] last_rdata;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic scramble_req();
        req_we       = 1'($urandom);
        req_size     = 2'($urandom);
        req_unsigned = 1'($urandom);
        req_addr     = $urandom;
        req_wdata    = $urandom;
    endtask

    // Issue one request and check latency, memory traffic and response against the reference.
    task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd);
        logic        err, got, r_err;
        logic [31:0] word, exp_rdata, exp_word, mask, lane, r_dat;
        int          sh, exp_lat, exp_rd, exp_wr, n, lat, rdc, wrc;
        logic [7:0]  idx;
        err = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0) || (a >= 32'd1024);
        idx = a[9:2];
        word = ref_mem[idx];
        exp_rdata = 32'd0;
        exp_word = word;
        exp_rd = 0;
        exp_wr = 0;
        if (err) begin
            exp_lat = 1;
        end else if (!we) begin
            exp_lat = 2;
            exp_rd = 1;
            if (sz == 2'd0) begin
                sh = int'(a[1:0]) * 8;
                lane = (word >> sh) & 32'hFF;
                exp_rdata = (!uns && lane >= 32'd128) ? (lane | 32'hFFFF_FF00) : lane;
            end else if (sz == 2'd1) begin
                sh = int'(a[1]) * 16;
                lane = (word >> sh) & 32'hFFFF;
                exp_rdata = (!uns && lane >= 32'd32768) ? (lane | 32'hFFFF_0000) : lane;
            end else begin
                exp_rdata = word;
            end
        end else if (sz == 2'd2) begin
            exp_lat = 2;
            exp_wr = 1;
            exp_word = wd;
        end else begin
            exp_lat = 3;
            exp_rd = 1;
            exp_wr = 1;
            sh = (sz == 2'd0) ? int'(a[1:0]) * 8 : int'(a[1]) * 16;
            mask = ((sz == 2'd0) ? 32'hFF : 32'hFFFF) << sh;
            exp_word = (word & ~mask) | ((wd << sh) & mask);
        end

        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = a; req_wdata = wd;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) check("ready_timeout", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        scramble_req();

        lat = 0; rdc = 0; wrc = 0; got = 1'b0; r_dat = 32'd0; r_err = 1'b0;
        while (!got && lat < 10) begin
            @(negedge clk);
            lat++;
            if (MemRead) begin
                rdc++;
                check("rd_addr", address, {a[31:2], 2'b00});
            end
            if (MemWr) begin
                wrc++;
                check("wr_addr", address, {a[31:2], 2'b00});
                check("wr_data", Wr_data, exp_word);
            end
            if (resp_valid) begin
                got = 1'b1;
                r_dat = resp_rdata;
                r_err = resp_err;
            end
        end
        check("latency", got ? 32'(lat) : 32'd99, 32'(exp_lat));
        check("rdata", r_dat, exp_rdata);
        check("err", 32'(r_err), 32'(err));
        check("memread_cycles", 32'(rdc), 32'(exp_rd));
        check("memwr_cycles", 32'(wrc), 32'(exp_wr));
        if (we && !err) begin
            check("mem_word", mem[idx], exp_word);
            ref_mem[idx] = exp_word;
        end
        last_rdata = r_dat;
    endtask

    initial begin
        int n, acc_cyc, rv_cnt;
        logic [31:0] a;
        logic [1:0]  sz;

        // Reset state, with memory preload while the unit is held in reset.
        #2;
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_err", 32'(resp_err), 32'd0);
        check("rst_memrd", 32'(MemRead), 32'd0);
        check("rst_memwr", 32'(MemWr), 32'd0);
        check("rst_address", address, 32'd0);
        check("rst_wrdata", Wr_data, 32'd0);
        check("rst_rdata", resp_rdata, 32'd0);
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            pl_en = 1'b1;
            pl_idx = 8'(i);
            pl_dat = (i == 4) ? 32'h8899_AABB : $urandom;
            ref_mem[i] = pl_dat;
        end
        @(negedge clk);
        pl_en = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check("ready_after_rst", 32'(req_ready), 32'd1);

        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        check("lw_const", last_rdata, 32'h8899_AABB);
        do_req(1'b0, 2'd0, 1'b0, 32'h13, 32'h0);
        check("lb_const", last_rdata, 32'hFFFF_FF88);
        do_req(1'b0, 2'd0, 1'b1, 32'h13, 32'h0);
        check("lbu_const", last_rdata, 32'h0000_0088);
        do_req(1'b0, 2'd1, 1'b0, 32'h12, 32'h0);
        check("lh_const", last_rdata, 32'hFFFF_8899);
        do_req(1'b0, 2'd1, 1'b1, 32'h10, 32'h0);
        check("lhu_const", last_rdata, 32'h0000_AABB);
        do_req(1'b1, 2'd0, 1'b0, 32'h11, 32'h1234_56CC);
        check("sb_const", mem[4], 32'h8899_CCBB);
        do_req(1'b1, 2'd1, 1'b0, 32'h12, 32'h0000_7777);
        check("sh_const", mem[4], 32'h7777_CCBB);
        do_req(1'b0, 2'd1, 1'b0, 32'h11, 32'h0);
        do_req(1'b1, 2'd2, 1'b0, 32'h402, 32'h1111_2222);
        do_req(1'b0, 2'd3, 1'b0, 32'h10, 32'h0);
        do_req(1'b1, 2'd2, 1'b0, 32'h3FC, 32'hCAFE_F00D);

        // Reset asserted mid-WR: strobe drops asynchronously and the store is lost.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_addr = 32'h20; req_wdata = 32'h5555_6666;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("wr_before_rst", 32'(MemWr), 32'd1);
        #1;
        reset = 1'b0;
        #1;
        check("memwr_async_drop", 32'(MemWr), 32'd0);
        check("ready_in_rst", 32'(req_ready), 32'd0);
        rv_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (resp_valid) rv_cnt++;
        end
        reset = 1'b1;
        #1;
        check("ready_after_release", 32'(req_ready), 32'd1);
        @(negedge clk);
        if (resp_valid) rv_cnt++;
        check("no_resp_after_abort", 32'(rv_cnt), 32'd0);
        check("aborted_store", mem[8], ref_mem[8]);

        // Back-to-back with req_valid held: SW 0x20 then LW 0x20.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
        req_addr = 32'h20; req_wdata = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        req_we = 1'b0;
        acc_cyc = 0; rv_cnt = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (resp_valid) begin
                rv_cnt++;
                if (rv_cnt == 1) check("b2b_store_lat", 32'(c), 32'd2);
                if (rv_cnt == 2) begin
                    check("b2b_load_lat", 32'(c), 32'd5);
                    check("b2b_load_data", resp_rdata, 32'hDEAD_BEEF);
                end
            end
            if (acc_cyc != 0 && req_valid) req_valid = 1'b0;
            if (req_ready && acc_cyc == 0 && req_valid) acc_cyc = c;
        end
        req_valid = 1'b0;
        check("b2b_accept_cycle", 32'(acc_cyc), 32'd3);
        check("b2b_resp_count", 32'(rv_cnt), 32'd2);
        ref_mem[8] = 32'hDEAD_BEEF;

        // Random traffic, mostly in range with some misalignment, reserved size and out-of-range.
        for (int t = 0; t < 200; t++) begin
            a = $urandom_range(0, 1023);
            if ($urandom_range(0, 9) == 0) a = a | (32'd1 << $urandom_range(10, 31));
            sz = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'd1) a[0] = 1'b0;
                if (sz == 2'd2) a[1:0] = 2'b00;
            end
            do_req(1'($urandom), sz, 1'($urandom), a, $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
